// File: rtl/turn_control_fsm.sv
// Turn controller for a tile-matching game: select, reveal, compare, win check.
// Moore FSM; every output is a register loaded from the next-state decode.
module turn_control_fsm #(
  parameter int unsigned REVEAL_CYCLES = 50_000_000,
  parameter int unsigned TURN_TIMEOUT  = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_valid,
  input  logic [3:0] sel_tile,
  input  logic       go,
  input  logic       W,
  output logic [3:0] position_data,
  output logic       A,
  output logic       B,
  output logic       statecombo_next_turn,
  output logic       reveal_on,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    REVEAL = 3'd2,
    CHECK  = 3'd3,
    WAITGO = 3'd4,
    WINCHK = 3'd5,
    NEXT   = 3'd6,
    OVER   = 3'd7
  } state_e;

  localparam logic [31:0] REVEAL_LAST = 32'(REVEAL_CYCLES - 1);
  localparam logic [31:0] TMO_LAST    = 32'(TURN_TIMEOUT - 1);
  localparam logic [31:0] TIMER_MAX   = '1;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  pos_q, pos_d;
  logic        a_q, b_q, nt_q, rev_q, over_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SELECT;
      end
      SELECT: begin
        // A selection in the timeout cycle still wins.
        if (sel_valid) begin
          state_d = REVEAL;
          pos_d   = sel_tile;
        end else if (timer_q >= TMO_LAST) begin
          state_d = NEXT;
        end
      end
      REVEAL: begin
        if (timer_q >= REVEAL_LAST) state_d = CHECK;
      end
      CHECK: begin
        state_d = WAITGO;
      end
      WAITGO: begin
        state_d = go ? WINCHK : NEXT;
      end
      WINCHK: begin
        state_d = W ? OVER : SELECT;
      end
      NEXT: begin
        state_d = SELECT;
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 32'd1;
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pos_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      nt_q    <= 1'b0;
      rev_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      a_q     <= (state_d == CHECK);
      b_q     <= (state_d == WINCHK);
      nt_q    <= (state_d == NEXT);
      rev_q   <= (state_d == REVEAL);
      over_q  <= (state_d == OVER);
    end
  end

  assign position_data        = pos_q;
  assign A                    = a_q;
  assign B                    = b_q;
  assign statecombo_next_turn = nt_q;
  assign reveal_on            = rev_q;
  assign game_over            = over_q;
  assign state                = state_q;

`ifndef SYNTHESIS
  a_strobe_excl : assert property (
    @(posedge clk) disable iff (rst)
    $onehot0({a_q, b_q, nt_q}));

  a_strobe_single : assert property (
    @(posedge clk) disable iff (rst)
    (a_q | b_q | nt_q) |=> !(a_q | b_q | nt_q));

  a_over_holds : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == OVER) |=> (state_q == OVER));
`endif

endmodule

// File: tb/tb_turn_control_fsm.sv
// Vector table plus hand sequences for turn_control_fsm.
// Small REVEAL/TIMEOUT values keep every path short.
module tb_turn_control_fsm;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sel_valid;
  logic [3:0] sel_tile;
  logic       go;
  logic       W;
  logic [3:0] position_data;
  logic       A;
  logic       B;
  logic       nt;
  logic       reveal_on;
  logic       game_over;
  logic [2:0] state;

  int total;
  int passed;

  turn_control_fsm #(
    .REVEAL_CYCLES(4),
    .TURN_TIMEOUT (10)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .sel_valid           (sel_valid),
    .sel_tile            (sel_tile),
    .go                  (go),
    .W                   (W),
    .position_data       (position_data),
    .A                   (A),
    .B                   (B),
    .statecombo_next_turn(nt),
    .reveal_on           (reveal_on),
    .game_over           (game_over),
    .state               (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sv;
    logic [3:0]  tile;
    logic        g;
    logic        w;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {state, position_data, A, B, next_turn, reveal_on, game_over}
  function automatic logic [11:0] outs();
    return {state, position_data, A, B, nt, reveal_on, game_over};
  endfunction

  task automatic chk(input string name, input logic [11:0] got,
                     input logic [11:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic add(input logic s, input logic sv, input logic [3:0] t,
                     input logic g, input logic w,
                     input logic [2:0] es, input logic [3:0] ep,
                     input logic ea, input logic eb, input logic en,
                     input logic er, input logic eo);
    vec_t v;
    v.st   = s;
    v.sv   = sv;
    v.tile = t;
    v.g    = g;
    v.w    = w;
    v.exp  = {es, ep, ea, eb, en, er, eo};
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input logic [2:0] es,
                      input logic [3:0] ep, input logic er,
                      input logic eo);
    for (int i = 0; i < n; i++)
      add(0, 0, 4'h0, 0, 0, es, ep, 0, 0, 0, er, eo);
  endtask

  task automatic drive(input logic s, input logic sv, input logic [3:0] t,
                       input logic g, input logic w);
    start     = s;
    sel_valid = sv;
    sel_tile  = t;
    go        = g;
    W         = w;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic prev_strobe;
  logic [2:0] cur_strobe;

  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      cur_strobe = {A, B, nt};
      total++;
      if (!$onehot0(cur_strobe) || (prev_strobe && |cur_strobe))
        $display("FAIL strobe_rule: got %b prev %b required onehot0/no repeat",
                 cur_strobe, prev_strobe);
      else
        passed++;
      prev_strobe = |cur_strobe;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    drive(0, 0, 4'h0, 0, 0);

    // sel_valid in IDLE ignored, then miss path on tile 5
    add(0, 1, 4'h7, 0, 0, 3'd0, 4'h0, 0, 0, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 3'd1, 4'h0, 0, 0, 0, 0, 0);
    add(0, 1, 4'h5, 0, 0, 3'd2, 4'h5, 0, 0, 0, 1, 0);
    idle(3, 3'd2, 4'h5, 1, 0);
    add(0, 0, 4'h0, 0, 0, 3'd3, 4'h5, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd4, 4'h5, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd6, 4'h5, 0, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd1, 4'h5, 0, 0, 0, 0, 0);
    // match without win on tile 3, stray selection of F mid-reveal
    add(0, 1, 4'h3, 0, 0, 3'd2, 4'h3, 0, 0, 0, 1, 0);
    add(0, 1, 4'hF, 0, 0, 3'd2, 4'h3, 0, 0, 0, 1, 0);
    idle(2, 3'd2, 4'h3, 1, 0);
    add(0, 0, 4'h0, 0, 0, 3'd3, 4'h3, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd4, 4'h3, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 3'd5, 4'h3, 0, 1, 0, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd1, 4'h3, 0, 0, 0, 0, 0);
    // timeout: ten idle SELECT cycles forfeit the turn
    idle(9, 3'd1, 4'h3, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd6, 4'h3, 0, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd1, 4'h3, 0, 0, 0, 0, 0);
    // selection in the tenth cycle beats the timeout
    idle(9, 3'd1, 4'h3, 0, 0);
    add(0, 1, 4'hA, 0, 0, 3'd2, 4'hA, 0, 0, 0, 1, 0);
    idle(3, 3'd2, 4'hA, 1, 0);
    add(0, 0, 4'h0, 0, 0, 3'd3, 4'hA, 1, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 0, 3'd4, 4'hA, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 3'd5, 4'hA, 0, 1, 0, 0, 0);
    // win, then OVER ignores start and sel_valid
    add(0, 0, 4'h0, 0, 1, 3'd7, 4'hA, 0, 0, 0, 0, 1);
    add(1, 0, 4'h0, 0, 0, 3'd7, 4'hA, 0, 0, 0, 0, 1);
    add(0, 1, 4'h1, 0, 0, 3'd7, 4'hA, 0, 0, 0, 0, 1);
    idle(1, 3'd7, 4'hA, 0, 1);

    #3;
    chk("reset_state", outs(), 12'h000);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sv, vecs[i].tile, vecs[i].g, vecs[i].w);
      cyc();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    drive(0, 0, 4'h0, 0, 0);

    // rst leaves OVER immediately, without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("rst_from_over", outs(), 12'h000);
    cyc();
    rst = 1'b0;

    // reset in the second REVEAL cycle
    drive(1, 0, 4'h0, 0, 0);
    cyc();
    drive(0, 1, 4'h6, 0, 0);
    cyc();
    drive(0, 0, 4'h0, 0, 0);
    cyc();
    chk("reveal_cycle2", outs(), {3'd2, 4'h6, 5'b00010});
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_reveal", outs(), 12'h000);
    cyc();
    rst = 1'b0;
    drive(0, 1, 4'h9, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("post_rst_idle%0d", i), outs(), 12'h000);
    end
    drive(1, 0, 4'h0, 0, 0);
    cyc();
    drive(0, 0, 4'h0, 0, 0);
    chk("restart_select", outs(), {3'd1, 4'h0, 5'b00000});
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/turn_control_fsm.md
TURN_CONTROL_FSM -- requirements
Module: turn_control_fsm

Interface
REQ-001 Parameter REVEAL_CYCLES, default 50_000_000: number of cycles the chosen tile stays revealed before comparison.
REQ-002 Parameter TURN_TIMEOUT, default 500_000_000: number of idle cycles in SELECT before the turn is forfeited.
REQ-003 clk  in  1  single clock; all state changes occur on the rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 start  in  1  single-cycle pulse that begins a game.
REQ-006 sel_valid  in  1  single-cycle pulse marking the player's tile choice.
REQ-007 sel_tile  in  4  index of the chosen tile; qualified by sel_valid.
REQ-008 go  in  1  match result from the data path; valid one cycle after A.
REQ-009 W  in  1  win flag from the data path; combinational and valid in the same cycle as B.
REQ-010 position_data  out  4  latched tile index, fed to the data path.
REQ-011 A  out  1  one-cycle compare strobe.
REQ-012 B  out  1  one-cycle win-check strobe.
REQ-013 statecombo_next_turn  out  1  one-cycle pulse that advances to the next player.
REQ-014 reveal_on  out  1  high while the chosen tile is displayed.
REQ-015 game_over  out  1  high in OVER.
REQ-016 state  out  3  current state encoding, for debug and display.

Function
REQ-017 The block SHALL implement a Moore FSM with fixed encodings: IDLE=0, SELECT=1, REVEAL=2, CHECK=3, WAITGO=4, WINCHK=5, NEXT=6, OVER=7.
REQ-018 IDLE: start=1 SHALL move to SELECT; all other inputs are ignored.
REQ-019 SELECT: sel_valid=1 SHALL latch sel_tile into position_data, clear the timer, and move to REVEAL.
REQ-020 SELECT: the timer SHALL count cycles without a selection; when it reaches TURN_TIMEOUT-1 with sel_valid=0, the FSM SHALL move to NEXT and leave position_data unchanged.
REQ-021 SELECT: if sel_valid=1 arrives in the same cycle as the timeout, the selection SHALL win.
REQ-022 REVEAL: reveal_on=1 for exactly REVEAL_CYCLES cycles, after which the FSM SHALL move to CHECK.
REQ-023 CHECK: A=1 for exactly one cycle, after which the FSM SHALL move to WAITGO.
REQ-024 WAITGO: go SHALL be sampled; go=1 moves to WINCHK, go=0 moves to NEXT.
REQ-025 WINCHK: B=1 for one cycle and W SHALL be sampled in that same cycle; W=1 moves to OVER, W=0 moves to SELECT so the same player picks again.
REQ-026 NEXT: statecombo_next_turn=1 for exactly one cycle, after which the FSM SHALL move to SELECT with the timer cleared.
REQ-027 OVER: game_over=1 and the FSM SHALL hold; start and sel_valid are ignored, and only rst exits.
REQ-028 sel_valid SHALL be ignored in every state except SELECT, and position_data SHALL change only on an accepted selection.
REQ-029 The strobes A, B and statecombo_next_turn SHALL never be high simultaneously and never high for two consecutive cycles.
REQ-030 The timer SHALL be 32 bits wide, SHALL saturate and never wrap, and SHALL be cleared on every state entry.
REQ-031 All outputs SHALL be registered or decoded from the state register only, never combinationally from inputs.

Reset
REQ-032 On rst=1 the block SHALL immediately, asynchronously, and from any state (including mid-REVEAL) set: state=IDLE, position_data=0, timer=0, A=B=statecombo_next_turn=reveal_on=game_over=0.
REQ-033 After rst deasserts, the FSM SHALL remain in IDLE until the first start pulse.

Verification
Bench settings: REVEAL_CYCLES=4, TURN_TIMEOUT=10.
REQ-034 Miss path: start, then sel_valid with sel_tile=0x5 and go=0 -> position_data=5, reveal_on high 4 cycles, A pulses once, then statecombo_next_turn pulses once and state=1.
REQ-035 Match without win: go=1 and W=0 after a selection of tile 0x3 -> B pulses once, state returns to 1, and no statecombo_next_turn pulse occurs.
REQ-036 Win: go=1 and W=1 -> state=7 and game_over=1; later start and sel_valid pulses leave state at 7.
REQ-037 Timeout: no sel_valid for 10 cycles in SELECT -> one statecombo_next_turn pulse, position_data unchanged; sel_valid on the 10th cycle -> REVEAL is taken instead.
REQ-038 Ignored input: sel_valid pulsed during REVEAL with sel_tile=0xF -> position_data keeps its earlier value.
REQ-039 Reset mid-operation: rst asserted in cycle 2 of REVEAL -> in the same cycle state=0, reveal_on=0, position_data=0; no strobe fires afterwards.
